waveform_sequencer: RTL and testbench

- Controller that sequences the waveform generator through a programmed list of tones. Drives the generator's enable and 16-bit phase increment.
- Holds a small table of (increment, dwell) entries. Each entry plays for its dwell time in clock cycles, then the next entry follows; playback runs once or loops.
- Sits between the board control logic (switches/buttons/config writes) and waveformGenerator_TOP. gen_ready comes from the generator's waveformEnabled.

---
 rtl/waveform_sequencer.sv | 138 +++++++++++++
 tb/tb_waveform_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/waveform_sequencer.sv
// waveform_sequencer: steps the waveform generator through a table of (increment, dwell) tones.
// Define WFSEQ_GAP_EN to insert a GAP_CYCLES silent gap between consecutive steps.
module waveform_sequencer #(
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 3,
   parameter int INC_W      = 16,
   parameter int DWELL_W    = 24,
   parameter int GAP_CYCLES = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [ADDR_W-1:0]  cfg_addr,
   input  logic [INC_W-1:0]   cfg_increment,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [ADDR_W:0]    seq_len,
   input  logic               loop,
   input  logic               start,
   input  logic               stop,
   input  logic               gen_ready,
   output logic               gen_enable,
   output logic [INC_W-1:0]   gen_increment,
   output logic [ADDR_W-1:0]  step_idx,
   output logic               busy,
   output logic               done
);
   typedef enum logic [2:0] {IDLE, ARM, PLAY, GAP, FINISH} state_t;
   state_t state, state_n;
   logic [INC_W-1:0]   inc_mem   [DEPTH];
   logic [DWELL_W-1:0] dwell_mem [DEPTH];
   logic [DWELL_W-1:0] cnt, cnt_n, dwell_sel;
   logic [ADDR_W-1:0]  step_n, nxt_step, tgt;
   logic [ADDR_W:0]    len_q;
   logic               loop_q, start_ok, last, load;
   logic               gen_enable_n, busy_n, done_n;
   logic [INC_W-1:0]   inc_n;
`ifdef WFSEQ_GAP_EN
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   logic [GAP_W-1:0]   gap_cnt, gap_n;
`endif
   assign start_ok  = start && !stop && seq_len != '0 && seq_len <= (ADDR_W+1)'(DEPTH);
   assign last      = {1'b0, step_idx} == len_q - 1'b1;
   assign nxt_step  = last ? '0 : step_idx + 1'b1;
   // entry whose increment/dwell gets loaded on a step boundary
   assign tgt       = state == PLAY ? nxt_step : state == IDLE ? '0 : step_idx;
   assign dwell_sel = dwell_mem[tgt] == '0 ? DWELL_W'(1) : dwell_mem[tgt];
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state         <= IDLE;
         step_idx      <= '0;
         gen_increment <= '0;
         gen_enable    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         cnt           <= '0;
         len_q         <= '0;
         loop_q        <= 1'b0;
`ifdef WFSEQ_GAP_EN
         gap_cnt       <= '0;
`endif
      end else begin
         state         <= state_n;
         step_idx      <= step_n;
         gen_increment <= inc_n;
         gen_enable    <= gen_enable_n;
         busy          <= busy_n;
         done          <= done_n;
         cnt           <= cnt_n;
`ifdef WFSEQ_GAP_EN
         gap_cnt       <= gap_n;
`endif
         if (state == IDLE && start_ok) begin
            len_q  <= seq_len;
            loop_q <= loop;
         end
      end
   always_ff @(posedge clk)
      if (cfg_we && state == IDLE) begin
         inc_mem[cfg_addr]   <= cfg_increment;
         dwell_mem[cfg_addr] <= cfg_dwell;
      end
   always_comb begin
      state_n = state;
      step_n  = step_idx;
      cnt_n   = cnt;
      load    = 1'b0;
`ifdef WFSEQ_GAP_EN
      gap_n   = gap_cnt;
`endif
      case (state)
         IDLE: if (start_ok) begin
            state_n = ARM;
            load    = 1'b1;
         end
         ARM: if (gen_ready) state_n = PLAY;
         PLAY: if (gen_ready) begin
            if (cnt != DWELL_W'(1)) cnt_n = cnt - 1'b1;
            else if (last && !loop_q) state_n = FINISH;
`ifdef WFSEQ_GAP_EN
            else begin
               state_n = GAP;
               step_n  = nxt_step;
               gap_n   = GAP_W'(GAP_CYCLES);
            end
`else
            else load = 1'b1;
`endif
         end
`ifdef WFSEQ_GAP_EN
         GAP: if (gap_cnt != GAP_W'(1)) gap_n = gap_cnt - 1'b1;
         else begin
            state_n = ARM;
            load    = 1'b1;
         end
`endif
         FINISH: begin
            state_n = IDLE;
            step_n  = '0;
         end
         default: state_n = IDLE;
      endcase
      if (load) begin
         step_n = tgt;
         cnt_n  = dwell_sel;
      end
      if (stop && state != IDLE) begin
         state_n = IDLE;
         step_n  = '0;
         load    = 1'b0;
      end
   end
   always_comb begin
      gen_enable_n = state_n == ARM || state_n == PLAY;
      busy_n       = state_n != IDLE;
      done_n       = state_n == FINISH;
      inc_n        = load ? inc_mem[tgt] : gen_increment;
   end
endmodule

// File: tb/tb_waveform_sequencer.sv
// tb_waveform_sequencer: per-cycle expected outputs are queued when a run is launched, then popped and compared.
module tb_waveform_sequencer;
   localparam int GAP = 16;
   typedef struct packed {
      logic        en;
      logic [15:0] inc;
      logic [2:0]  step;
      logic        busy;
      logic        done;
   } exp_t;
   logic clk = 1'b0, reset = 1'b1;
   logic cfg_we = 1'b0;
   logic [2:0] cfg_addr = '0;
   logic [15:0] cfg_increment = '0;
   logic [23:0] cfg_dwell = '0;
   logic [3:0] seq_len = '0;
   logic loop = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, ready_d = 1'b0;
   logic gen_ready, gen_enable, busy, done;
   logic [15:0] gen_increment;
   logic [2:0] step_idx;
   exp_t sb[$];
   exp_t e, got;
   int passed = 0, total = 0;
   int tinc[8], tdw[8];
   logic [15:0] cur_inc = '0;

   waveform_sequencer dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_increment(cfg_increment), .cfg_dwell(cfg_dwell), .seq_len(seq_len),
      .loop(loop), .start(start), .stop(stop), .gen_ready(gen_ready),
      .gen_enable(gen_enable), .gen_increment(gen_increment), .step_idx(step_idx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   // generator model: waveformEnabled follows enable one clock later, gated by a test pause
   always @(posedge clk) ready_d <= gen_enable;
   assign gen_ready = ready_d && !pause;
   assign got = {gen_enable, gen_increment, step_idx, busy, done};

   function automatic exp_t mk(input logic en, input int inc, input int step, input logic bsy, input logic dn);
      return {en, 16'(inc), 3'(step), bsy, dn};
   endfunction

   task automatic exp_play(input int idx, input bit first, input int extra);
`ifdef WFSEQ_GAP_EN
      if (!first) repeat (GAP) sb.push_back(mk(1'b0, cur_inc, idx, 1'b1, 1'b0));
      first = 1'b1;
`endif
      cur_inc = 16'(tinc[idx]);
      if (first) repeat (2) sb.push_back(mk(1'b1, cur_inc, idx, 1'b1, 1'b0));
      repeat ((tdw[idx] == 0 ? 1 : tdw[idx]) + extra) sb.push_back(mk(1'b1, cur_inc, idx, 1'b1, 1'b0));
   endtask

   task automatic exp_end(input int last_idx, input int idle);
      if (last_idx >= 0) sb.push_back(mk(1'b0, cur_inc, last_idx, 1'b1, 1'b1));
      repeat (idle) sb.push_back(mk(1'b0, cur_inc, 0, 1'b0, 1'b0));
   endtask

   task automatic write_entry(input int a, input int inc, input int dw);
      cfg_we = 1'b1; cfg_addr = 3'(a); cfg_increment = 16'(inc); cfg_dwell = 24'(dw);
      tinc[a] = inc; tdw[a] = dw;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic test_reset;
      exp_t z;
      z = mk(1'b0, 0, 0, 1'b0, 1'b0);
      seq_len = 4'd2;
      #2 reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         total++;
         if (got !== z) $display("FAIL reset: cycle %0d got %h expected %h", i, got, z);
         else passed++;
         start = ~start;
      end
      start = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (got !== z) $display("FAIL idle_after_reset: cycle %0d got %h expected %h", i, got, z);
         else passed++;
      end
   endtask

   task automatic test_single_run;
      write_entry(0, 21475, 10);
      write_entry(1, 10000, 5);
      seq_len = 4'd2; loop = 1'b0; start = 1'b1;
      exp_play(0, 1'b1, 0); exp_play(1, 1'b0, 0); exp_end(1, 3);
      for (int i = 1; sb.size() != 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (got !== e) $display("FAIL single_run: cycle %0d got %h expected %h", i, got, e);
         else passed++;
         start = 1'b0;
         seq_len = 4'd1; loop = 1'b1;
         cfg_we = i == 4; cfg_addr = '0; cfg_increment = 16'd999; cfg_dwell = 24'd3;
      end
      cfg_we = 1'b0; loop = 1'b0;
   endtask

   task automatic test_loop_stop;
      int stop_at;
      seq_len = 4'd2; loop = 1'b1; start = 1'b1;
      exp_play(0, 1'b1, 0); exp_play(1, 1'b0, 0);
      repeat (3) begin exp_play(0, 1'b0, 0); exp_play(1, 1'b0, 0); end
      repeat (3) void'(sb.pop_back());
      stop_at = sb.size();
      exp_end(-1, 3);
      for (int i = 1; sb.size() != 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (got !== e) $display("FAIL loop_stop: cycle %0d got %h expected %h", i, got, e);
         else passed++;
         start = 1'b0;
         stop = i == stop_at;
      end
      stop = 1'b0; loop = 1'b0;
   endtask

   task automatic test_pause;
      seq_len = 4'd2; loop = 1'b0; start = 1'b1;
      exp_play(0, 1'b1, 7); exp_play(1, 1'b0, 0); exp_end(1, 2);
      for (int i = 1; sb.size() != 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (got !== e) $display("FAIL pause: cycle %0d got %h expected %h", i, got, e);
         else passed++;
         start = 1'b0;
         pause = i >= 5 && i < 12;
      end
      pause = 1'b0;
   endtask

   task automatic test_edge_cases;
      for (int c = 0; c < 3; c++) begin
         seq_len = c == 0 ? 4'd0 : c == 1 ? 4'd9 : 4'd2;
         stop = c == 2; start = 1'b1;
         exp_end(-1, 3);
         for (int i = 1; sb.size() != 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (got !== e) $display("FAIL ignored_start case %0d: cycle %0d got %h expected %h", c, i, got, e);
            else passed++;
            start = 1'b0; stop = 1'b0;
         end
      end
      write_entry(2, 3333, 0);
      seq_len = 4'd3; loop = 1'b0; start = 1'b1;
      exp_play(0, 1'b1, 0); exp_play(1, 1'b0, 0); exp_play(2, 1'b0, 0); exp_end(2, 2);
      for (int i = 1; sb.size() != 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (got !== e) $display("FAIL zero_dwell: cycle %0d got %h expected %h", i, got, e);
         else passed++;
         start = 1'b0;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

   initial begin
      test_reset;
      test_single_run;
      test_loop_stop;
      test_pause;
      test_edge_cases;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
